// File: rtl/freq_range_ctrl.sv
// Range controller for the DDFS/VGA DAC sample-clock divider.
// Steps freq_cntrl from debounced buttons or an automatic sweep, applying changes only on div_clk falls.

module freq_range_debounce #(
    parameter int CYCLES = 500000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt reloads whenever the synced input agrees with the accepted level,
    // so the level only flips after CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= sync[1];
                cnt   <= RELOAD;
                press <= sync[1];
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// State table:
//   ST_IDLE | no request outstanding; buttons accepted, or sweep runs when sweep_en=1
//   ST_PEND | button request held in target, applied on the next div_clk fall
module freq_range_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DWELL_TICKS     = 8,
    parameter int RESET_RANGE     = 3
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       sweep_en,
    input  logic       div_clk,
    output logic [2:0] freq_cntrl,
    output logic       busy,
    output logic       range_changed,
    output logic       at_min,
    output logic       at_max
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [2:0] RANGE_MAX  = 3'd6;
    localparam logic [2:0] RANGE_INIT = 3'(RESET_RANGE);
    localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);

    logic       up_press;
    logic       down_press;
    logic [0:0] state;
    logic [2:0] target;
    logic [7:0] dwell;
    logic       div_q;
    logic       fall;

    freq_range_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .btn    (btn_up),
        .press  (up_press)
    );

    freq_range_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .btn    (btn_down),
        .press  (down_press)
    );

    // div_clk shares clk_in, so a registered copy is enough to find its falling edge.
    assign fall = div_q & ~div_clk;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            freq_cntrl    <= RANGE_INIT;
            target        <= RANGE_INIT;
            dwell         <= 8'd0;
            div_q         <= 1'b0;
            range_changed <= 1'b0;
        end else begin
            div_q         <= div_clk;
            range_changed <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sweep_en) begin
                        if (fall) begin
                            if (dwell == DWELL_LAST) begin
                                dwell         <= 8'd0;
                                freq_cntrl    <= (freq_cntrl == RANGE_MAX) ? 3'd0 : freq_cntrl + 3'd1;
                                range_changed <= 1'b1;
                            end else begin
                                dwell <= dwell + 8'd1;
                            end
                        end
                    end else begin
                        dwell <= 8'd0;
                        if (up_press && !down_press && freq_cntrl != RANGE_MAX) begin
                            target <= freq_cntrl + 3'd1;
                            state  <= ST_PEND;
                        end else if (down_press && !up_press && freq_cntrl != 3'd0) begin
                            target <= freq_cntrl - 3'd1;
                            state  <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    // A fall in the accept cycle was seen in IDLE, so any fall here is a later one.
                    dwell <= 8'd0;
                    if (fall) begin
                        freq_cntrl    <= target;
                        range_changed <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    dwell <= 8'd0;
                end
            endcase
        end
    end

    assign busy   = (state == ST_PEND);
    assign at_min = (freq_cntrl == 3'd0);
    assign at_max = (freq_cntrl == RANGE_MAX);
endmodule

// File: tb/tb_freq_range_ctrl.sv
// Scoreboard bench for freq_range_ctrl: a model divider feeds div_clk back,
// stimulus pushes expected ranges, a monitor pops them on each range_changed pulse.
`timescale 1ns/1ps
module tb_freq_range_ctrl;
    localparam int DEB       = 4;
    localparam int DWELL     = 2;
    localparam int RST_RANGE = 3;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       sweep_en;
    logic       div_clk = 1'b0;
    logic [2:0] freq_cntrl;
    logic       busy;
    logic       range_changed;
    logic       at_min;
    logic       at_max;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    int   div_cnt     = 0;
    logic div_q_m     = 1'b0;
    int   total_falls = 0;

    freq_range_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_TICKS     (DWELL),
        .RESET_RANGE     (RST_RANGE)
    ) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .sweep_en      (sweep_en),
        .div_clk       (div_clk),
        .freq_cntrl    (freq_cntrl),
        .busy          (busy),
        .range_changed (range_changed),
        .at_min        (at_min),
        .at_max        (at_max)
    );

    always #5 clk_in = ~clk_in;

    // Model divider: half period of 8*(range+1) clocks, count never reset.
    always @(posedge clk_in) begin
        if (div_cnt == 0) begin
            div_clk <= ~div_clk;
            div_cnt <= 8 * (int'(freq_cntrl) + 1) - 1;
        end else begin
            div_cnt <= div_cnt - 1;
        end
    end

    always @(posedge clk_in) begin
        if (div_q_m && !div_clk) total_falls <= total_falls + 1;
        div_q_m <= div_clk;
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_busy(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk_in);
            if (busy) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int bound, output bit done);
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk_in);
            if (!busy) done = 1'b1;
        end
    endtask

    task automatic wait_div_fall();
        bit was_hi = 1'b0;
        bit found  = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk_in);
            if (div_clk) was_hi = 1'b1;
            else if (was_hi) found = 1'b1;
        end
        check("div_fall_seen", found, 1);
    endtask

    task automatic press_expect(input bit up, input int exp);
        bit seen;
        bit done;
        exp_q.push_back(exp);
        btn_up   = up;
        btn_down = !up;
        wait_busy(20, seen);
        check("press_busy", seen, 1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_idle(300, done);
        check("press_done", done, 1);
        repeat (DEB + 6) step();
        check("press_value", freq_cntrl, exp);
    endtask

    task automatic press_ignored(input bit up, input bit dn, input string name);
        bit saw = 1'b0;
        btn_up   = up;
        btn_down = dn;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (busy) saw = 1'b1;
        end
        check(name, saw, 0);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (DEB + 6) step();
    endtask

    // Pops one expected range per range_changed pulse; any freq_cntrl move without a pulse is an error.
    task automatic monitor();
        int         cool      = 2;
        int         sweep_ref = 0;
        logic [2:0] fc_prev   = 3'd0;
        logic       rc_prev   = 1'b0;
        logic       sw_prev   = 1'b0;
        int         exp;
        forever begin
            @(negedge clk_in);
            if (!rst_n) begin
                cool    = 2;
                rc_prev = 1'b0;
            end else begin
                if (sweep_en && !sw_prev) sweep_ref = total_falls;
                if (range_changed) begin
                    check("rc_single_cycle", rc_prev, 0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_change: freq_cntrl=%0d, no change pending at %0t", freq_cntrl, $time);
                    end else begin
                        exp = exp_q.pop_front();
                        check("range_value", freq_cntrl, exp);
                    end
                    if (sweep_en) begin
                        check("sweep_dwell_falls", total_falls - sweep_ref, DWELL);
                        sweep_ref = total_falls;
                    end
                end else if (cool == 0) begin
                    check("stable_without_pulse", freq_cntrl, fc_prev);
                end
                if (cool > 0) cool--;
                rc_prev = range_changed;
            end
            fc_prev = freq_cntrl;
            sw_prev = sweep_en;
        end
    endtask

    initial begin
        bit seen;
        bit done;
        bit saw_busy;
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        sweep_en = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset_range", freq_cntrl, RST_RANGE);
        check("reset_busy", busy, 0);
        check("reset_at_min", at_min, 0);
        check("reset_at_max", at_max, 0);
        check("reset_rc", range_changed, 0);

        press_expect(1'b1, 4);

        // Bounce: toggling every 2 clocks never holds for DEB samples.
        exp_q.push_back(5);
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            repeat (2) step();
        end
        btn_up = 1'b1;
        wait_busy(30, seen);
        check("bounce_busy", seen, 1);
        btn_up = 1'b0;
        wait_idle(300, done);
        check("bounce_done", done, 1);
        repeat (DEB + 6) step();
        check("bounce_value", freq_cntrl, 5);

        press_expect(1'b1, 6);
        press_ignored(1'b1, 1'b0, "up_at_max_busy");
        check("up_at_max_value", freq_cntrl, 6);
        check("up_at_max_flag", at_max, 1);
        check("up_at_max_min_flag", at_min, 0);

        for (int v = 5; v >= 0; v--) press_expect(1'b0, v);
        press_ignored(1'b0, 1'b1, "down_at_min_busy");
        check("down_at_min_value", freq_cntrl, 0);
        check("down_at_min_flag", at_min, 1);
        check("down_at_min_max_flag", at_max, 0);

        press_ignored(1'b1, 1'b1, "both_pressed_busy");
        check("both_pressed_value", freq_cntrl, 0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("idle_reset_range", freq_cntrl, RST_RANGE);

        // Second up press lands while the first request is still pending.
        wait_div_fall();
        exp_q.push_back(4);
        btn_up = 1'b1;
        wait_busy(20, seen);
        check("pend_busy", seen, 1);
        btn_up = 1'b0;
        repeat (DEB + 4) step();
        btn_up = 1'b1;
        repeat (DEB + 6) step();
        check("pend_still_busy", busy, 1);
        btn_up = 1'b0;
        wait_idle(300, done);
        check("pend_done", done, 1);
        repeat (120) step();
        check("pend_single_value", freq_cntrl, 4);

        press_expect(1'b1, 5);

        // Sweep 5->6->0->1 with buttons pressed along the way.
        exp_q.push_back(6);
        exp_q.push_back(0);
        exp_q.push_back(1);
        sweep_en = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            @(negedge clk_in);
            if (busy) saw_busy = 1'b1;
            if (i == 20) btn_up = 1'b1;
            if (i == 40) btn_up = 1'b0;
            if (i == 60) btn_down = 1'b1;
            if (i == 80) btn_down = 1'b0;
        end
        sweep_en = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        check("sweep_all_changes", exp_q.size(), 0);
        check("sweep_no_busy", saw_busy, 0);
        repeat (20) step();
        check("sweep_final_value", freq_cntrl, 1);

        // Reset while a request is pending discards it.
        wait_div_fall();
        btn_up = 1'b1;
        wait_busy(20, seen);
        check("rst_pend_busy", seen, 1);
        btn_up = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_pend_busy_cleared", busy, 0);
        check("rst_pend_range", freq_cntrl, RST_RANGE);
        repeat (300) step();
        check("rst_pend_range_held", freq_cntrl, RST_RANGE);
        check("rst_pend_still_idle", busy, 0);

        check("no_leftover_expect", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
